// File: rtl/instr_refresh_arbiter.sv
// Purpose: merges host instruction bundles with periodic refresh bundles into one output register.
// Latency: one cycle from an S-side handshake to the bundle appearing on M; one bundle per cycle.
// Backpressure: S_TREADY follows the output slot and drops while a refresh is urgent. Build option: REFRESH_STATS_EN.
module instr_refresh_arbiter #(
   parameter int                      INSTR_WIDTH   = 128,
   parameter int                      TREFI_CYCLES  = 7800,
   parameter int                      MAX_POSTPONE  = 8,
   parameter int                      URGENT_THRESH = 6,
   parameter int                      IDLE_GAP      = 4,
   parameter logic [INSTR_WIDTH-1:0]  REF_BUNDLE    = INSTR_WIDTH'(6)
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  refresh_enable,
   input  logic [INSTR_WIDTH-1:0]                S_AXIS_HOST_TDATA,
   input  logic                                  S_AXIS_HOST_TVALID,
   output logic                                  S_AXIS_HOST_TREADY,
   output logic [INSTR_WIDTH-1:0]                M_AXIS_INSTR_TDATA,
   output logic                                  M_AXIS_INSTR_TVALID,
   input  logic                                  M_AXIS_INSTR_TREADY,
   output logic                                  M_AXIS_INSTR_TUSER,
   output logic [$clog2(MAX_POSTPONE+1)-1:0]     ref_pending,
   output logic                                  ref_overflow,
   output logic [31:0]                           stat_ref_issued,
   output logic [31:0]                           stat_ref_forced
);

   localparam int PW = $clog2(MAX_POSTPONE + 1);
   localparam int CW = (TREFI_CYCLES > 1) ? $clog2(TREFI_CYCLES) : 1;
   localparam int IW = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;

   localparam logic [CW-1:0] C_RELOAD = CW'(TREFI_CYCLES - 1);
   localparam logic [PW-1:0] C_MAXP   = PW'(MAX_POSTPONE);
   localparam logic [PW-1:0] C_URG    = PW'(URGENT_THRESH);
   localparam logic [IW-1:0] C_GAP    = IW'(IDLE_GAP);

   logic [CW-1:0]          r_intv;
   logic [PW-1:0]          r_pending;
   logic                   r_ovf;
   logic [IW-1:0]          r_idle;
   logic                   r_m_vld;
   logic                   r_m_user;
   logic [INSTR_WIDTH-1:0] r_m_dat;

   logic w_slot_free;
   logic w_urgent;
   logic w_tick;
   logic w_ld_urg;
   logic w_ld_host;
   logic w_ld_opp;
   logic w_ld_ref;

   // The output slot can take a new bundle when empty or being drained this cycle.
   assign w_slot_free = !r_m_vld || M_AXIS_INSTR_TREADY;
   assign w_urgent    = (r_pending >= C_URG);
   assign w_tick      = refresh_enable && (r_intv == '0);

   // Load priority: forced refresh, then host, then opportunistic refresh after an idle gap.
   assign w_ld_urg  = w_slot_free && w_urgent;
   assign w_ld_host = w_slot_free && !w_urgent && S_AXIS_HOST_TVALID;
   assign w_ld_opp  = w_slot_free && !w_urgent && !S_AXIS_HOST_TVALID &&
                      (r_pending != '0) && (r_idle == C_GAP);
   assign w_ld_ref  = w_ld_urg || w_ld_opp;

   // Ready never looks at S TVALID so the host cannot form a combinational loop through us.
   assign S_AXIS_HOST_TREADY  = w_slot_free && !w_urgent;
   assign M_AXIS_INSTR_TDATA  = r_m_dat;
   assign M_AXIS_INSTR_TVALID = r_m_vld;
   assign M_AXIS_INSTR_TUSER  = r_m_user;
   assign ref_pending         = r_pending;
   assign ref_overflow        = r_ovf;

   // Refresh interval down-counter; freezes while refresh is disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_intv <= C_RELOAD;
      end else if (refresh_enable) begin
         r_intv <= (r_intv == '0) ? C_RELOAD : r_intv - CW'(1);
      end
   end

   // Postponed-refresh credit count with sticky overflow when a tick finds it saturated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
         r_ovf     <= 1'b0;
      end else begin
         case ({w_tick, w_ld_ref})
            2'b10: begin
               if (r_pending == C_MAXP) r_ovf <= 1'b1;
               else                     r_pending <= r_pending + PW'(1);
            end
            2'b01:   r_pending <= r_pending - PW'(1);
            default: ;
         endcase
      end
   end

   // Counts consecutive host-idle cycles, saturating at the required gap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idle <= '0;
      end else if (S_AXIS_HOST_TVALID) begin
         r_idle <= '0;
      end else if (r_idle != C_GAP) begin
         r_idle <= r_idle + IW'(1);
      end
   end

   // Single-stage output register; contents hold while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m_vld  <= 1'b0;
         r_m_user <= 1'b0;
         r_m_dat  <= '0;
      end else if (w_slot_free) begin
         if (w_ld_ref) begin
            r_m_vld  <= 1'b1;
            r_m_user <= 1'b1;
            r_m_dat  <= REF_BUNDLE;
         end else if (w_ld_host) begin
            r_m_vld  <= 1'b1;
            r_m_user <= 1'b0;
            r_m_dat  <= S_AXIS_HOST_TDATA;
         end else begin
            r_m_vld  <= 1'b0;
         end
      end
   end

`ifdef REFRESH_STATS_EN
   logic [31:0] r_stat_issued;
   logic [31:0] r_stat_forced;

   // Free-running wrap-around counters of refresh loads, total and forced.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_issued <= '0;
         r_stat_forced <= '0;
      end else begin
         if (w_ld_ref) r_stat_issued <= r_stat_issued + 32'd1;
         if (w_ld_urg) r_stat_forced <= r_stat_forced + 32'd1;
      end
   end

   assign stat_ref_issued = r_stat_issued;
   assign stat_ref_forced = r_stat_forced;
`else
   assign stat_ref_issued = '0;
   assign stat_ref_forced = '0;
`endif

endmodule
